aurora_flow_nfc_arbiter: RTL and testbench
==========================================

Name: aurora_flow_nfc_arbiter

Overview:
Shares the single Aurora native-flow-control (NFC) channel between NUM_REQ message requesters, e.g. per-FIFO flow-control generators and a host-issued NFC source. Each requester offers one 16-bit NFC word. The word 16'hffff means XOFF and 16'h0000 means XON. The block grants requesters round-robin, with XOFF requests taking strict precedence over all others. It holds the granted word on the s_axi_nfc stream until the core accepts it, then enforces a minimum idle gap before the next grant. It also keeps message and stall statistics for the host.

Parameters:
- NUM_REQ, 4: number of requesters; must be 2 to 8.
- MIN_GAP, 2: idle cycles forced after each accepted NFC word; 0 is legal.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: reset; asynchronous, active-high.
- counter_reset, input, 1: synchronous clear of the statistics counters.
- req_valid, input, NUM_REQ: bit i high means requester i has a word pending.
- req_data, input, 16*NUM_REQ: word of requester i, in bits [16i+15:16i].
- req_ready, output, NUM_REQ: one-cycle accept pulse to the granted requester.
- s_axi_nfc_tready, input, 1: core accepts the NFC word.
- s_axi_nfc_tvalid, output, 1: NFC word valid.
- s_axi_nfc_tdata, output, 16: NFC word.
- grant_src, output, 3: index of the requester last granted.
- msg_count, output, CNT_WIDTH: NFC words transferred.
- xoff_count, output, CNT_WIDTH: transferred words equal to 16'hffff.
- stall_cycles, output, CNT_WIDTH: total cycles with tvalid=1 and tready=0.
- max_stall, output, CNT_WIDTH: longest single stall run, in cycles.

Behaviour:
- Reset (rst=1, asynchronous):
  - FSM goes to IDLE; all outputs are 0.
  - Round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority.
  - A word in flight is dropped and is not replayed.
- IDLE state:
  - If any req_valid bit is set, select one requester and assert its req_ready for exactly that cycle.
  - Latch its data into s_axi_nfc_tdata, set grant_src, and go to SEND.
  - With no requests, stay in IDLE.
- Selection rule:
  - If any valid requester has data 16'hffff, choose among XOFF requesters only.
  - Otherwise choose among all valid requesters.
  - Within the chosen set, pick the first index after the pointer, wrapping modulo NUM_REQ.
  - The pointer updates to the granted index.
- SEND state:
  - s_axi_nfc_tvalid=1; tdata is held stable.
  - When tready=1, the word transfers: go to GAP if MIN_GAP>0, otherwise to IDLE.
  - tvalid never drops before the transfer.
- GAP state: tvalid=0 for exactly MIN_GAP cycles, then IDLE. Requests are ignored during GAP.
- Latency:
  - req_ready pulses in cycle t; tvalid is high from cycle t+1.
  - With tready held at 1, one grant is made every 2+MIN_GAP cycles.
- req_ready is one-hot or zero, and is never asserted outside IDLE.
- Counters:
  - msg_count increments on each transfer; xoff_count also increments if the word is 16'hffff.
  - stall_cycles increments on every SEND cycle with tready=0.
  - A run counter tracks the current stall. On each stall cycle, if run+1 > max_stall, then max_stall <= run+1. The run counter clears on transfer.
  - All counters saturate at all-ones and do not wrap.
- counter_reset:
  - Clears msg_count, xoff_count, stall_cycles, max_stall and the run counter.
  - It wins over any increment in the same cycle.
  - It does not affect the FSM, pointer or stream.
- A requester that deasserts req_valid while it is not granted loses nothing. Requesters must keep req_data stable while req_valid=1.

Test Plan:
- Reset: assert rst mid-SEND. Required: tvalid=0, tdata=0, req_ready=0, all counters 0; after release, requester 0 wins when all are valid.
- Single request: requester 2 offers 16'h0000 with tready=1. Required: req_ready[2] pulses in cycle t; tvalid=1 and tdata=0000 in t+1; tvalid=0 for t+2 and t+3; msg_count=1, grant_src=2.
- Round-robin: all four valid with 16'h0000, tready=1, MIN_GAP=2. Required: grants go 0,1,2,3,0 at 4-cycle spacing; msg_count=5 after 20 cycles; xoff_count=0.
- XOFF precedence: requester 0 offers 0000 and requester 3 offers ffff at the same time. Required: requester 3 is granted first and tdata=ffff; requester 0 follows after the gap; xoff_count=1.
- Backpressure: hold tready=0 for 7 cycles, transfer, then a second word stalls 3 cycles. Required: tdata stable throughout each stall; stall_cycles=10, max_stall=7, msg_count=2.
- Counter reset: pulse counter_reset in the same cycle as a transfer. Required: next cycle all counters read 0, and the stream completes normally.

Source files
------------

// File: rtl/aurora_flow_nfc_arbiter.sv
// aurora_flow_nfc_arbiter: shares the Aurora NFC channel round-robin with XOFF precedence,
// a forced idle gap after each word, and host-visible message/stall statistics.
module aurora_flow_nfc_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MIN_GAP   = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   counter_reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   s_axi_nfc_tready,
  output logic                   s_axi_nfc_tvalid,
  output logic [15:0]            s_axi_nfc_tdata,
  output logic [2:0]             grant_src,
  output logic [CNT_WIDTH-1:0]   msg_count,
  output logic [CNT_WIDTH-1:0]   xoff_count,
  output logic [CNT_WIDTH-1:0]   stall_cycles,
  output logic [CNT_WIDTH-1:0]   max_stall
);
  localparam int GW = MIN_GAP > 1 ? $clog2(MIN_GAP) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t               state;
  logic [2:0]           ptr, sel_lo, sel_hi, sel;
  logic                 has_hi, xfer, stall;
  logic [NUM_REQ-1:0]   xoff, cand;
  logic [15:0]          word;
  logic [GW-1:0]        gap_cnt;
  logic [CNT_WIDTH-1:0] run, run_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction

  // Indices above the pointer win over wrapped ones; within each half the lowest index wins.
  always_comb begin
    xoff = '0;
    for (int i = 0; i < NUM_REQ; i++) xoff[i] = req_valid[i] && (&req_data[16*i +: 16]);
    cand = |xoff ? xoff : req_valid;
    sel_lo = '0;
    sel_hi = '0;
    has_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i] && 3'(i) <= ptr) sel_lo = 3'(i);
      if (cand[i] && 3'(i) > ptr) begin
        sel_hi = 3'(i);
        has_hi = 1'b1;
      end
    end
    sel = has_hi ? sel_hi : sel_lo;
    word = '0;
    for (int i = 0; i < NUM_REQ; i++) if (3'(i) == sel) word = req_data[16*i +: 16];
  end

  assign req_ready = (state == IDLE && |req_valid && !rst) ? NUM_REQ'(1) << sel : '0;
  assign xfer      = state == SEND && s_axi_nfc_tready;
  assign stall     = state == SEND && !s_axi_nfc_tready;
  assign run_inc   = sat_inc(run);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= 3'(NUM_REQ - 1);
      s_axi_nfc_tvalid <= 1'b0;
      s_axi_nfc_tdata  <= '0;
      grant_src        <= '0;
      gap_cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          ptr              <= sel;
          grant_src        <= sel;
          s_axi_nfc_tdata  <= word;
          s_axi_nfc_tvalid <= 1'b1;
          state            <= SEND;
        end
        SEND: if (s_axi_nfc_tready) begin
          s_axi_nfc_tvalid <= 1'b0;
          gap_cnt          <= GW'(MIN_GAP - 1);
          state            <= MIN_GAP > 0 ? GAP : IDLE;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || counter_reset) begin
      msg_count    <= '0;
      xoff_count   <= '0;
      stall_cycles <= '0;
      max_stall    <= '0;
      run          <= '0;
    end else begin
      if (xfer) begin
        msg_count <= sat_inc(msg_count);
        if (&s_axi_nfc_tdata) xoff_count <= sat_inc(xoff_count);
        run <= '0;
      end
      if (stall) begin
        stall_cycles <= sat_inc(stall_cycles);
        run          <= run_inc;
        if (run_inc > max_stall) max_stall <= run_inc;
      end
    end
  end
endmodule

// File: tb/tb_aurora_flow_nfc_arbiter.sv
// tb_aurora_flow_nfc_arbiter: directed and random stimulus against a transaction-level model
// with a scoreboard queue of expected NFC words popped by an independent monitor.
module tb_aurora_flow_nfc_arbiter;
  localparam int N = 4, G = 2, W = 32;
  logic              clk = 0, rst = 1, counter_reset = 0, tready = 0;
  logic [N-1:0]      req_valid = '0, req_ready;
  logic [16*N-1:0]   req_data = '0;
  logic              tvalid;
  logic [15:0]       tdata;
  logic [2:0]        grant_src;
  logic [W-1:0]      msg_count, xoff_count, stall_cycles, max_stall;

  aurora_flow_nfc_arbiter #(.NUM_REQ(N), .MIN_GAP(G), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .counter_reset(counter_reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .s_axi_nfc_tready(tready), .s_axi_nfc_tvalid(tvalid), .s_axi_nfc_tdata(tdata),
    .grant_src(grant_src), .msg_count(msg_count), .xoff_count(xoff_count),
    .stall_cycles(stall_cycles), .max_stall(max_stall)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit pend[N];
  logic [15:0] pdata[N];
  int cyc = 0, m_elig = 0, m_ptr = N - 1, m_src = 0;
  bit m_out = 0;
  logic [15:0] m_word = '0;
  longint m_msg = 0, m_xoff = 0, m_stall = 0, m_max = 0, m_run = 0;
  bit started = 0;
  logic [N-1:0] e_rdy = '0;
  bit e_tv = 0;
  logic [15:0] e_td = '0;
  int e_src = 0;
  longint e_msg = 0, e_xoff = 0, e_stall = 0, e_max = 0;
  logic [18:0] q[$];

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic add(input int i, input logic [15:0] d);
    if (!pend[i]) begin
      pend[i] = 1;
      pdata[i] = d;
    end
  endtask

  // One clock of stimulus; the model works on whole words: who is pending, when the
  // channel becomes free again, and which word is outstanding.
  task automatic cycle(input bit tr, input bit cr = 0, input bit r = 0);
    int s, j;
    bit xo;
    @(posedge clk);
    #1;
    rst = r;
    tready = tr;
    counter_reset = cr;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[16*i +: 16] = pdata[i];
    end
    started = 1;
    if (r) begin
      m_out = 0; m_word = '0; m_src = 0; m_ptr = N - 1; m_elig = 0;
      m_msg = 0; m_xoff = 0; m_stall = 0; m_max = 0; m_run = 0;
      q.delete();
    end
    e_rdy = '0;
    e_tv = m_out; e_td = m_word; e_src = m_src;
    e_msg = m_msg; e_xoff = m_xoff; e_stall = m_stall; e_max = m_max;
    if (!r) begin
      if (m_out && tr) begin
        m_msg++;
        if (m_word == 16'hffff) m_xoff++;
        m_run = 0;
        m_out = 0;
        m_elig = cyc + 1 + G;
      end else if (m_out) begin
        m_stall++;
        m_run++;
        if (m_run > m_max) m_max = m_run;
      end else if (cyc >= m_elig) begin
        xo = 0;
        for (int i = 0; i < N; i++) if (pend[i] && pdata[i] == 16'hffff) xo = 1;
        s = -1;
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (s < 0 && pend[j] && (!xo || pdata[j] == 16'hffff)) s = j;
        end
        if (s >= 0) begin
          e_rdy[s] = 1'b1;
          m_ptr = s; m_src = s; m_word = pdata[s]; m_out = 1; pend[s] = 0;
          q.push_back({3'(s), pdata[s]});
        end
      end
      if (cr) begin
        m_msg = 0; m_xoff = 0; m_stall = 0; m_max = 0; m_run = 0;
      end
    end
    cyc++;
  endtask

  always @(negedge clk) if (started) begin
    logic [18:0] x;
    chk("req_ready", req_ready, e_rdy);
    chk("tvalid", tvalid, e_tv);
    chk("tdata", tdata, e_td);
    chk("grant_src", grant_src, e_src);
    chk("msg_count", msg_count, e_msg);
    chk("xoff_count", xoff_count, e_xoff);
    chk("stall_cycles", stall_cycles, e_stall);
    chk("max_stall", max_stall, e_max);
    if (tvalid && tready && !rst) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: transfer of %0h with empty queue (cycle %0d)", tdata, cyc);
      end else begin
        x = q.pop_front();
        chk("xfer_data", tdata, x[15:0]);
        chk("xfer_src", grant_src, x[18:16]);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      pdata[i] = '0;
    end
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    add(2, 16'h0000);
    repeat (6) cycle(1);
    repeat (20) begin
      for (int i = 0; i < N; i++) add(i, 16'h0000);
      cycle(1);
    end
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (6) cycle(1);
    add(0, 16'h0000);
    add(3, 16'hffff);
    repeat (10) cycle(1);
    cycle(1, 1);
    add(1, 16'h1234);
    cycle(1);
    repeat (7) cycle(0);
    repeat (3) cycle(1);
    add(2, 16'h00ff);
    cycle(1);
    repeat (3) cycle(0);
    repeat (4) cycle(1);
    add(0, 16'h5a5a);
    cycle(1);
    cycle(1, 1);
    repeat (4) cycle(1);
    add(1, 16'h0000);
    repeat (3) cycle(0);
    for (int i = 0; i < N; i++) add(i, 16'h0000);
    cycle(0, 0, 1);
    repeat (6) cycle(1);
    repeat (900) begin
      int i;
      i = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) == 0)
        case ($urandom_range(0, 3))
          0: add(i, 16'hffff);
          1: add(i, 16'h0000);
          default: add(i, 16'($urandom));
        endcase
      else if ($urandom_range(0, 19) == 0) pend[i] = 0;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 300) == 0);
    end
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (10) cycle(1);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
